// File: rtl/RS5_pkg.sv
// RS5_pkg
// Shared definitions for the RS5 core slice.
// Provides the multiply operation encoding used by the iterative multiplier.
//   mul_op_e : 2-bit operation select (MUL, MULH, MULHSU, MULHU)
package RS5_pkg;

    // MUL returns the low product word; the three MULH variants return the
    // high word and differ only in how each operand is sign-extended.
    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

endpackage

// File: rtl/mul_digit_mac.sv
// mul_digit_mac
// Combinational multiply-accumulate for one multiplier digit.
// Multiplies the sign-extended multiplicand by digit digit_idx of b,
// shifts the partial product into place and adds it to the accumulator.
// Ports:
//   acc        : current 2*XLEN accumulator
//   a_ext      : multiplicand with its extension sign as bit XLEN
//   b          : full multiplier word
//   b_signed   : when set, the top digit carries a negative MSB weight
//   digit_idx  : index of the digit retired this cycle
//   acc_next   : accumulator after adding this digit's partial product
module mul_digit_mac #(
    parameter int XLEN    = 32,
    parameter int DIGIT_W = 8,
    parameter int CNT_W   = 3
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN:0]     a_ext,
    input  logic [XLEN-1:0]   b,
    input  logic              b_signed,
    input  logic [CNT_W-1:0]  digit_idx,
    output logic [2*XLEN-1:0] acc_next
);

    localparam int N = XLEN / DIGIT_W;

    logic [31:0]        shift_amt;
    logic [DIGIT_W-1:0] digit;
    logic               digit_neg;
    logic [2*XLEN-1:0]  a_wide;
    logic [2*XLEN-1:0]  d_wide;
    logic [2*XLEN-1:0]  product;

    // Only the low 2*XLEN bits of the result are kept, so both operands are
    // sign-extended straight to 2*XLEN and multiplied modulo 2^(2*XLEN);
    // this matches the (XLEN+1)x(DIGIT_W+1) signed product truncated there.
    always_comb begin
        shift_amt = 32'(digit_idx) * 32'(DIGIT_W);
        digit     = DIGIT_W'(b >> shift_amt);
        digit_neg = b_signed && (digit_idx == CNT_W'(N - 1)) && digit[DIGIT_W-1];
        a_wide    = {{(XLEN - 1){a_ext[XLEN]}}, a_ext};
        d_wide    = {{(2*XLEN - DIGIT_W){digit_neg}}, digit};
        product   = a_wide * d_wide;
        acc_next  = acc + (product << shift_amt);
    end

endmodule

// File: rtl/mul_iter.sv
// mul_iter
// Iterative multiplier retiring one DIGIT_W-bit multiplier digit per cycle.
// A product takes N = XLEN/DIGIT_W calculation cycles, or none when either
// operand is zero.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   start_i           : request, accepted when ready_o is high and kill_i low
//   kill_i            : abort the operation being calculated
//   op_i              : MUL / MULH / MULHSU / MULHU
//   first_operand_i   : multiplicand A
//   second_operand_i  : multiplier B
//   ready_o           : a start can be accepted this cycle
//   valid_o           : one-cycle pulse marking a new result_o
//   result_o          : product word, held until the next result
module mul_iter
    import RS5_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DIGIT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            kill_i,
    input  mul_op_e         op_i,
    input  logic [XLEN-1:0] first_operand_i,
    input  logic [XLEN-1:0] second_operand_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int N     = XLEN / DIGIT_W;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state;
    state_e            state_next;
    mul_op_e           op_reg;
    logic [XLEN:0]     a_ext;
    logic [XLEN-1:0]   b_reg;
    logic              b_signed;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              zero_op;
    logic              last_digit;
    logic              a_sign;

    mul_digit_mac #(
        .XLEN    (XLEN),
        .DIGIT_W (DIGIT_W),
        .CNT_W   (CNT_W)
    ) u_mac (
        .acc       (acc),
        .a_ext     (a_ext),
        .b         (b_reg),
        .b_signed  (b_signed),
        .digit_idx (cnt),
        .acc_next  (acc_next)
    );

    // Next-state and handshake decode. A zero operand skips straight to DONE,
    // whether the request arrives in IDLE or back-to-back in DONE.
    always_comb begin
        ready_o    = (state != CALC);
        valid_o    = (state == DONE);
        accept     = start_i && ready_o && !kill_i;
        zero_op    = (first_operand_i == '0) || (second_operand_i == '0);
        last_digit = (cnt == CNT_W'(N - 1));
        a_sign     = ((op_i == MULH) || (op_i == MULHSU)) && first_operand_i[XLEN-1];
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = zero_op ? DONE : CALC;
            end
            CALC: begin
                if (kill_i)          state_next = IDLE;
                else if (last_digit) state_next = DONE;
            end
            DONE: begin
                if (accept) state_next = zero_op ? DONE : CALC;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, digit accumulation and result update. result_o only
    // changes on the edge that enters DONE, so a kill leaves it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_reg   <= MUL;
            a_ext    <= '0;
            b_reg    <= '0;
            b_signed <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            result_o <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_reg   <= op_i;
                a_ext    <= {a_sign, first_operand_i};
                b_reg    <= second_operand_i;
                b_signed <= (op_i == MULH);
                acc      <= '0;
                cnt      <= '0;
                if (zero_op) result_o <= '0;
            end else if ((state == CALC) && !kill_i) begin
                acc <= acc_next;
                cnt <= cnt + CNT_W'(1);
                if (last_digit) begin
                    result_o <= (op_reg == MUL) ? acc_next[XLEN-1:0]
                                                : acc_next[2*XLEN-1:XLEN];
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter
// Self-checking bench for mul_iter at XLEN=32, DIGIT_W=8.
// Expected products come from a plain-arithmetic 66-bit signed reference.
module tb_mul_iter;
    import RS5_pkg::*;

    localparam int XLEN    = 32;
    localparam int DIGIT_W = 8;
    localparam int N       = XLEN / DIGIT_W;
    localparam int MAX_LAT = 20;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_i;
    logic            kill_i;
    mul_op_e         op_i;
    logic [XLEN-1:0] first_operand_i;
    logic [XLEN-1:0] second_operand_i;
    logic            ready_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    int checks = 0;
    int fails  = 0;

    mul_iter #(.XLEN(XLEN), .DIGIT_W(DIGIT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .start_i          (start_i),
        .kill_i           (kill_i),
        .op_i             (op_i),
        .first_operand_i  (first_operand_i),
        .second_operand_i (second_operand_i),
        .ready_o          (ready_o),
        .valid_o          (valid_o),
        .result_o         (result_o)
    );

    always #5 clk = ~clk;

    // Reference: extend each operand per its signedness, multiply, pick a word.
    function automatic logic [XLEN-1:0] ref_mul(input mul_op_e op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic signed [65:0] sa, sb, p;
        logic a_s, b_s;
        a_s = (op == MULH) || (op == MULHSU);
        b_s = (op == MULH);
        sa  = a_s ? {{34{a[XLEN-1]}}, a} : {34'b0, a};
        sb  = b_s ? {{34{b[XLEN-1]}}, b} : {34'b0, b};
        p   = sa * sb;
        return (op == MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic int ref_lat(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return ((a == 0) || (b == 0)) ? 1 : N + 1;
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request in the current cycle (ready_o must be high) and run
    // until valid_o or the cycle budget. Ends inside the DONE cycle.
    task automatic do_op(input mul_op_e op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, output logic [XLEN-1:0] res,
                         output int lat, output bit early_change);
        logic [XLEN-1:0] prev;
        prev             = result_o;
        early_change     = 1'b0;
        start_i          = 1'b1;
        op_i             = op;
        first_operand_i  = a;
        second_operand_i = b;
        step();
        start_i = 1'b0;
        lat     = 1;
        while (!valid_o && lat < MAX_LAT) begin
            if (result_o !== prev) early_change = 1'b1;
            step();
            lat++;
        end
        res = result_o;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({ready_o, valid_o, result_o} !== {1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("[TB] FAIL reset_state: ready/valid/result %b/%b/%h, want 1/0/00000000",
                     ready_o, valid_o, result_o);
        end
    endtask

    task automatic test_directed();
        logic [XLEN-1:0] res;
        int lat;
        bit early;
        mul_op_e ops[4] = '{MULH, MULHSU, MULHU, MUL};
        logic [XLEN-1:0] as[4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [XLEN-1:0] bs[4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [XLEN-1:0] exp_r[4] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], res, lat, early);
            checks++;
            if (res !== exp_r[i]) begin
                fails++;
                $display("[TB] FAIL directed_result[%0d]: got %h, want %h", i, res, exp_r[i]);
            end
            checks++;
            if (lat != N + 1) begin
                fails++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, N + 1);
            end
            checks++;
            if (early) begin
                fails++;
                $display("[TB] FAIL directed_hold[%0d]: result changed before DONE, want held", i);
            end
            step();
        end
    endtask

    task automatic test_zero();
        logic [XLEN-1:0] res;
        int lat;
        bit early;
        do_op(MUL, 32'h12345678, 32'h0, res, lat, early);
        checks++;
        if (lat != 1 || res !== 32'h0 || ready_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL zero_early_out: lat %0d result %h ready %b, want 1 00000000 1",
                     lat, res, ready_o);
        end
        step();
    endtask

    task automatic test_kill();
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] prev;
        int lat;
        bit early;
        bit saw_valid;
        do_op(MUL, 32'd3, 32'd5, res, lat, early);
        step();
        prev             = result_o;
        start_i          = 1'b1;
        op_i             = MULHU;
        first_operand_i  = 32'd7;
        second_operand_i = 32'd9;
        step();
        start_i = 1'b0;
        step();
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        checks++;
        if ({ready_o, valid_o} !== 2'b10 || result_o !== prev) begin
            fails++;
            $display("[TB] FAIL kill_abort: ready/valid %b/%b result %h, want 1/0 %h",
                     ready_o, valid_o, result_o, prev);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            if (valid_o) saw_valid = 1'b1;
            step();
        end
        checks++;
        if (saw_valid) begin
            fails++;
            $display("[TB] FAIL kill_no_valid: valid seen after kill, want none");
        end
        start_i = 1'b1;
        kill_i  = 1'b1;
        step();
        start_i = 1'b0;
        kill_i  = 1'b0;
        checks++;
        if ({ready_o, valid_o} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL start_with_kill: ready/valid %b/%b, want 1/0", ready_o, valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] res;
        int lat;
        bit early;
        do_op(MUL, 32'd3, 32'd5, res, lat, early);
        checks++;
        if (res !== 32'd15 || lat != N + 1) begin
            fails++;
            $display("[TB] FAIL b2b_first: result %0d lat %0d, want 15 %0d", res, lat, N + 1);
        end
        do_op(MUL, 32'd6, 32'd7, res, lat, early);
        checks++;
        if (res !== 32'd42 || lat != N + 1 || early) begin
            fails++;
            $display("[TB] FAIL b2b_second: result %0d lat %0d early %b, want 42 %0d 0",
                     res, lat, early, N + 1);
        end
        step();
    endtask

    task automatic test_reset_midop();
        bit saw_valid;
        start_i          = 1'b1;
        op_i             = MUL;
        first_operand_i  = 32'h0000_1234;
        second_operand_i = 32'h0000_5678;
        step();
        start_i = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({ready_o, valid_o, result_o} !== {1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("[TB] FAIL reset_midop: ready/valid/result %b/%b/%h, want 1/0/00000000",
                     ready_o, valid_o, result_o);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            if (valid_o) saw_valid = 1'b1;
            step();
        end
        checks++;
        if (saw_valid) begin
            fails++;
            $display("[TB] FAIL reset_midop_no_valid: valid seen after reset, want none");
        end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] res, a, b, exp_r;
        int lat;
        bit early;
        mul_op_e op;
        for (int i = 0; i < 60; i++) begin
            op = mul_op_e'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: a = '0;
                1: b = '0;
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            exp_r = ref_mul(op, a, b);
            do_op(op, a, b, res, lat, early);
            checks++;
            if (res !== exp_r || lat != ref_lat(a, b)) begin
                fails++;
                $display("[TB] FAIL random[%0d] op %0d a %h b %h: result %h lat %0d, want %h %0d",
                         i, op, a, b, res, lat, exp_r, ref_lat(a, b));
            end
            if ($urandom_range(0, 1) == 0) step();
        end
        step();
    endtask

    initial begin
        reset            = 1'b1;
        start_i          = 1'b0;
        kill_i           = 1'b0;
        op_i             = MUL;
        first_operand_i  = '0;
        second_operand_i = '0;
        #1;
        test_reset();
        test_directed();
        test_zero();
        test_kill();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
